// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state encoding and constants for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {DMEM_IDLE, DMEM_WAIT, DMEM_RESP} dmem_state_t;
  localparam logic [31:0] DMEM_BASE_DEFAULT = 32'h1001_0000;
  localparam int DMEM_WORD_W = 32;
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous word RAM with registered read
//   clk   clock
//   we    write enable; wdata written to addr on posedge
//   addr  word index
//   wdata write data
//   rdata registered read data of addr (read-before-write on same edge)
module dmem_ram import dmem_pkg::*; #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          addr,
  input  logic [DMEM_WORD_W-1:0] wdata,
  output logic [DMEM_WORD_W-1:0] rdata
);
  logic [DMEM_WORD_W-1:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: req/ready word load/store responder with wait states over a local RAM
//   clk    clock
//   reset  asynchronous active-low reset
//   req    transfer request, held with we/addr/wdata until ready
//   we     1 = store, 0 = load
//   addr   byte address
//   wdata  store data
//   rdata  load data, valid while ready=1
//   ready  one-cycle completion pulse
//   err    with ready: access rejected (out of range, or misaligned when enabled)
// Define DMEM_MISALIGN_ERR_EN to reject addresses with addr[1:0] != 0;
// otherwise the low address bits are ignored.
module data_memory_responder import dmem_pkg::*; #(
  parameter logic [31:0] ADDR_BASE   = DMEM_BASE_DEFAULT,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req,
  input  logic                   we,
  input  logic [31:0]            addr,
  input  logic [DMEM_WORD_W-1:0] wdata,
  output logic [DMEM_WORD_W-1:0] rdata,
  output logic                   ready,
  output logic                   err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  dmem_state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [31:0] lat_addr, off, sel_off;
  logic [DMEM_WORD_W-1:0] lat_wdata, ram_q;
  logic lat_we, hit, ok, last;
  logic unused_bits;
  assign off = lat_addr - ADDR_BASE;
  assign hit = lat_addr >= ADDR_BASE && {1'b0, off} < SPAN;
`ifdef DMEM_MISALIGN_ERR_EN
  assign ok = hit && lat_addr[1:0] == 2'b00;
`else
  assign ok = hit;
`endif
  // In IDLE the RAM reads the live address so a zero-wait load has its data
  // registered by the time RESP is entered; afterwards the latched address rules.
  assign sel_off = (state == DMEM_IDLE ? addr : lat_addr) - ADDR_BASE;
  assign unused_bits = ^{sel_off[31:AW+2], sel_off[1:0]};
  assign last = cnt == 4'(WAIT_STATES - 1);
  always_comb begin
    state_nx = state == DMEM_IDLE ? (req ? (WAIT_STATES > 0 ? DMEM_WAIT : DMEM_RESP) : DMEM_IDLE)
             : state == DMEM_WAIT ? (last ? DMEM_RESP : DMEM_WAIT)
             : DMEM_IDLE;
    cnt_nx = state == DMEM_WAIT && !last ? cnt + 4'd1 : 4'd0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= DMEM_IDLE;
      cnt       <= 4'd0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == DMEM_IDLE && req) begin
        lat_addr  <= addr;
        lat_we    <= we;
        lat_wdata <= wdata;
      end
    end
  end
  assign ready = state == DMEM_RESP;
  assign err   = ready && !ok;
  assign rdata = ready && ok && !lat_we ? ram_q : '0;
  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .we    (ready && ok && lat_we),
    .addr  (sel_off[AW+1:2]),
    .wdata (lat_wdata),
    .rdata (ram_q)
  );
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: randomized and directed checks of three responders (0, 1, 3 wait states)
module tb_data_memory_responder;
  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int DEPTH = 1024;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req [3];
  logic we [3];
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic ready [3];
  logic err [3];
  int checks = 0;
  int failures = 0;
  logic [31:0] model [3][DEPTH];
  bit valid [3][DEPTH];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_memory_responder #(
      .ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(g == 0 ? 0 : g == 1 ? 1 : 3)
    ) u_dut (
      .clk(clk), .reset(reset), .req(req[g]), .we(we[g]), .addr(addr[g]),
      .wdata(wdata[g]), .rdata(rdata[g]), .ready(ready[g]), .err(err[g])
    );
  end
  function automatic int ws(input int k);
    return k == 0 ? 0 : k == 1 ? 1 : 3;
  endfunction
  // Drives one transfer starting at a negedge with the DUT idle, returns the response
  // and the number of clock edges from the accepting edge to the edge that sees ready.
  task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input bit drop, output logic [31:0] rd, output logic e, output int lat);
    rd = '0;
    e = 1'b0;
    lat = 99;
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    @(posedge clk);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1 && drop) begin
        req[k] = 1'b0; we[k] = ~w; addr[k] = $urandom; wdata[k] = $urandom;
      end
      if (ready[k]) begin
        lat = n; rd = rdata[k]; e = err[k];
        break;
      end
    end
    req[k] = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks += 3;
      if (ready[k] !== 1'b0) begin failures++; $display("FAIL reset_ready[%0d] got=%b exp=0", k, ready[k]); end
      if (err[k] !== 1'b0) begin failures++; $display("FAIL reset_err[%0d] got=%b exp=0", k, err[k]); end
      if (rdata[k] !== 32'h0) begin failures++; $display("FAIL reset_rdata[%0d] got=%h exp=0", k, rdata[k]); end
    end
    reset = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_random;
    logic [31:0] a, d, rd, exp;
    logic w, e, hit, ok;
    bit drop, chk;
    int r, lat, idx;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 40; i++) begin
        r = $urandom_range(0, 9);
        a = r == 0 ? BASE - 32'(4 * $urandom_range(1, 4))
          : r == 1 ? BASE + 32'h1000 + 32'(4 * $urandom_range(0, 3))
          : r == 2 ? BASE + 32'hFFC
          : BASE + 32'(4 * $urandom_range(0, 7)) + (r == 3 ? 32'($urandom_range(0, 3)) : 32'h0);
        w = 1'($urandom_range(0, 1));
        d = $urandom;
        drop = 1'($urandom_range(0, 1));
        xfer(k, w, a, d, drop, rd, e, lat);
        hit = a >= BASE && (a - BASE) < 32'(4 * DEPTH);
`ifdef DMEM_MISALIGN_ERR_EN
        ok = hit && a[1:0] == 2'b00;
`else
        ok = hit;
`endif
        idx = ok ? int'((a - BASE) >> 2) : 0;
        chk = 1'b1;
        exp = 32'h0;
        if (!w && ok) begin
          chk = valid[k][idx];
          exp = model[k][idx];
        end
        if (w && ok) begin
          model[k][idx] = d;
          valid[k][idx] = 1'b1;
        end
        checks += 2;
        if (lat !== ws(k) + 1) begin failures++; $display("FAIL rand_latency[%0d] addr=%h got=%0d exp=%0d", k, a, lat, ws(k) + 1); end
        if (e !== !ok) begin failures++; $display("FAIL rand_err[%0d] addr=%h got=%b exp=%b", k, a, e, !ok); end
        if (chk) begin
          checks++;
          if (rd !== exp) begin failures++; $display("FAIL rand_rdata[%0d] addr=%h we=%b got=%h exp=%h", k, a, w, rd, exp); end
        end
      end
    end
  endtask
  task automatic test_abort_reset;
    logic [31:0] rd;
    logic e;
    int lat;
    xfer(2, 1'b1, BASE, 32'h0BAD_F00D, 1'b0, rd, e, lat);
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = BASE; wdata[2] = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    req[2] = 1'b0;
    reset = 1'b0;
    #1;
    checks += 3;
    if (ready[2] !== 1'b0) begin failures++; $display("FAIL abort_ready got=%b exp=0", ready[2]); end
    if (err[2] !== 1'b0) begin failures++; $display("FAIL abort_err got=%b exp=0", err[2]); end
    if (rdata[2] !== 32'h0) begin failures++; $display("FAIL abort_rdata got=%h exp=0", rdata[2]); end
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    xfer(2, 1'b0, BASE, 32'h0, 1'b0, rd, e, lat);
    checks += 2;
    if (rd !== 32'h0BAD_F00D) begin failures++; $display("FAIL abort_old_value got=%h exp=0badf00d", rd); end
    if (lat !== 4) begin failures++; $display("FAIL abort_latency got=%0d exp=4", lat); end
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = BASE - 32'h4;
    @(posedge clk);
    @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);
    checks += 2;
    if (ready[1] !== 1'b1) begin failures++; $display("FAIL resp_ready got=%b exp=1", ready[1]); end
    if (err[1] !== 1'b1) begin failures++; $display("FAIL resp_err got=%b exp=1", err[1]); end
    reset = 1'b0;
    #1;
    checks += 2;
    if (ready[1] !== 1'b0) begin failures++; $display("FAIL async_ready got=%b exp=0", ready[1]); end
    if (err[1] !== 1'b0) begin failures++; $display("FAIL async_err got=%b exp=0", err[1]); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_store_load;
    logic [31:0] rd;
    logic e;
    int lat;
    xfer(1, 1'b1, BASE + 32'h4, 32'hDEAD_BEEF, 1'b0, rd, e, lat);
    checks += 3;
    if (lat !== 2) begin failures++; $display("FAIL st_latency got=%0d exp=2", lat); end
    if (e !== 1'b0) begin failures++; $display("FAIL st_err got=%b exp=0", e); end
    if (rd !== 32'h0) begin failures++; $display("FAIL st_rdata got=%h exp=0", rd); end
    xfer(1, 1'b0, BASE + 32'h4, 32'h0, 1'b0, rd, e, lat);
    checks += 3;
    if (lat !== 2) begin failures++; $display("FAIL ld_latency got=%0d exp=2", lat); end
    if (e !== 1'b0) begin failures++; $display("FAIL ld_err got=%b exp=0", e); end
    if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ld_rdata got=%h exp=deadbeef", rd); end
  endtask
  task automatic test_out_of_range;
    logic [31:0] rd;
    logic e;
    int lat;
    xfer(1, 1'b1, BASE, 32'h5555_AAAA, 1'b0, rd, e, lat);
    xfer(1, 1'b0, 32'h1000_FFFC, 32'h0, 1'b0, rd, e, lat);
    checks += 2;
    if (e !== 1'b1) begin failures++; $display("FAIL below_err got=%b exp=1", e); end
    if (rd !== 32'h0) begin failures++; $display("FAIL below_rdata got=%h exp=0", rd); end
    xfer(1, 1'b0, 32'h1001_1000, 32'h0, 1'b0, rd, e, lat);
    checks += 2;
    if (e !== 1'b1) begin failures++; $display("FAIL above_err got=%b exp=1", e); end
    if (rd !== 32'h0) begin failures++; $display("FAIL above_rdata got=%h exp=0", rd); end
    xfer(1, 1'b1, 32'h1001_1000, 32'hFFFF_0000, 1'b0, rd, e, lat);
    checks++;
    if (e !== 1'b1) begin failures++; $display("FAIL above_store_err got=%b exp=1", e); end
    xfer(1, 1'b1, 32'h1000_FFFC, 32'hFFFF_0001, 1'b0, rd, e, lat);
    xfer(1, 1'b0, BASE, 32'h0, 1'b0, rd, e, lat);
    checks++;
    if (rd !== 32'h5555_AAAA) begin failures++; $display("FAIL miss_no_write got=%h exp=5555aaaa", rd); end
  endtask
  task automatic test_misalign;
    logic [31:0] rd, exp;
    logic e, exp_e;
    int lat;
    xfer(1, 1'b1, BASE + 32'h4, 32'h0101_0101, 1'b0, rd, e, lat);
    xfer(1, 1'b1, BASE + 32'h6, 32'hA5A5_5A5A, 1'b0, rd, e, lat);
`ifdef DMEM_MISALIGN_ERR_EN
    exp_e = 1'b1;
    exp = 32'h0101_0101;
`else
    exp_e = 1'b0;
    exp = 32'hA5A5_5A5A;
`endif
    checks++;
    if (e !== exp_e) begin failures++; $display("FAIL misalign_err got=%b exp=%b", e, exp_e); end
    xfer(1, 1'b0, BASE + 32'h4, 32'h0, 1'b0, rd, e, lat);
    checks++;
    if (rd !== exp) begin failures++; $display("FAIL misalign_word got=%h exp=%h", rd, exp); end
  endtask
  task automatic test_back_to_back;
    logic [31:0] rd;
    logic e;
    int lat;
    xfer(0, 1'b1, BASE + 32'h10, 32'hAAAA_0010, 1'b0, rd, e, lat);
    xfer(0, 1'b1, BASE + 32'h14, 32'hBBBB_0014, 1'b0, rd, e, lat);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = BASE + 32'h10;
    @(posedge clk);
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      checks++;
      if (ready[0] !== 1'(n % 2)) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", n, ready[0], 1'(n % 2)); end
      if (n == 1) begin
        checks++;
        if (rdata[0] !== 32'hAAAA_0010) begin failures++; $display("FAIL b2b_first got=%h exp=aaaa0010", rdata[0]); end
        addr[0] = BASE + 32'h14;
      end
      if (n == 3) begin
        checks++;
        if (rdata[0] !== 32'hBBBB_0014) begin failures++; $display("FAIL b2b_second got=%h exp=bbbb0014", rdata[0]); end
      end
    end
    req[0] = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_drop_req;
    logic [31:0] rd;
    logic e;
    int lat;
    xfer(2, 1'b1, BASE + 32'h8, 32'hC0FF_EE08, 1'b1, rd, e, lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL drop_st_latency got=%0d exp=4", lat); end
    xfer(2, 1'b0, BASE + 32'h8, 32'h0, 1'b1, rd, e, lat);
    checks += 3;
    if (lat !== 4) begin failures++; $display("FAIL drop_ld_latency got=%0d exp=4", lat); end
    if (e !== 1'b0) begin failures++; $display("FAIL drop_err got=%b exp=0", e); end
    if (rd !== 32'hC0FF_EE08) begin failures++; $display("FAIL drop_rdata got=%h exp=c0ffee08", rd); end
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
      for (int j = 0; j < DEPTH; j++) valid[k][j] = 1'b0;
    end
    test_reset;
    test_random;
    test_abort_reset;
    test_store_load;
    test_out_of_range;
    test_misalign;
    test_back_to_back;
    test_drop_req;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
